uart_rx_byte: RTL

- Receive-side deserializer for the UART link: turns the asynchronous serial `rx` line into 8-bit bytes for the downstream command/data logic.
- Sits directly behind the `rx` pin of the uart block.
- Frame format: 8N1, LSB first; 50 MHz system clock; 19200 baud by default.
- Uses a 16x oversampling tick, a 2-flop synchronizer, mid-bit sampling and a valid/ready output handshake with framing and overrun flags.

---
 rtl/uart_rx_byte.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling, mid-bit sampling, valid/ready output.
// Optional even-parity bit after data bit 7 when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
  parameter int OS_DIV  = 163,
  parameter int OS_RATE = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);
  localparam logic [3:0] OS_MID  = 4'(OS_RATE / 2 - 1);
  localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rxs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, div_clr;
  logic [3:0]       os_cnt, os_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             byte_done, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_nxt, perr_set;
`endif

  // Reset to the idle level so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (res) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Restarted on the start edge so every sample lands at a fixed phase from it.
  always_ff @(posedge clk) begin
    if (res || div_clr || tick) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    os_nxt    = os_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    div_clr   = 1'b0;
    byte_done = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          os_nxt    = '0;
          div_clr   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt == OS_MID) begin
            os_nxt  = '0;
            bit_nxt = '0;
            state_nxt = rxs ? IDLE : DATA;
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_nxt    = '0;
            shift_nxt = {rxs, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nxt   = PARITY;
              par_bad_nxt = 1'b0;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_idx + 3'd1;
            end
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_nxt    = '0;
            state_nxt = STOP;
            if (rxs != ^shift) begin
              perr_set    = 1'b1;
              par_bad_nxt = 1'b1;
            end
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_nxt = '0;
            if (rxs) begin
              state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
              byte_done = !par_bad;
`else
              byte_done = 1'b1;
`endif
            end else begin
              state_nxt = WAIT_IDLE;
              ferr_set  = 1'b1;
            end
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == START) || (state == DATA) ||
                (state == PARITY) || (state == STOP);

  // A completing byte wins over a same-edge handshake, keeping rx_valid high.
  always_ff @(posedge clk) begin
    if (res) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (res) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= perr_set;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
